ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM address width (depth 2**ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first address of burst; sampled with start.
REQ-007 SHALL have port length  input  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; sampled with start.
REQ-008 SHALL have port mem_addr  output  ADDR_WIDTH  registered address to RAM addr input.
REQ-009 SHALL have port mem_we  output  1  RAM write enable; constant 0.
REQ-010 SHALL have port mem_q  input  DATA_WIDTH  RAM read data; valid one cycle after mem_addr is sampled by RAM.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  streamed word.
REQ-012 SHALL have port out_valid  output  1  out_data holds a word.
REQ-013 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at rising edge.
REQ-014 SHALL have port busy  output  1  burst in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-016 SHALL implement states IDLE, READ (addresses left to issue), DRAIN (all issued, words pending).
REQ-017 IDLE & start & length!=0 SHALL go to READ, load mem_addr<=base_addr, remaining<=length.
REQ-018 IDLE & start & length==0 SHALL stay IDLE, pulse done next cycle, never assert out_valid.
REQ-019 start SHALL be ignored while not IDLE.
REQ-020 Read data SHALL be captured from mem_q into a 2-entry output FIFO, in address order.
REQ-021 A read SHALL be issued (address advanced) only when fifo_count + inflight < 2, inflight <= 1; words never lost or duplicated.
REQ-022 While no read is issued mem_addr SHALL hold, keeping mem_q stable.
REQ-023 mem_addr SHALL increment modulo 2**ADDR_WIDTH (2**ADDR_WIDTH-1 wraps to 0).
REQ-024 Latency: start at edge E0 -> first word on out_data with out_valid=1 after edge E0+2 (with out_ready=1 before).
REQ-025 Throughput: with out_ready held 1, SHALL sustain one word per cycle after first word.
REQ-026 While out_valid && !out_ready, out_data and out_valid SHALL stay stable.
REQ-027 out_valid SHALL equal fifo_count != 0; out_data SHALL be FIFO head.
REQ-028 READ -> DRAIN when last address issued; DRAIN -> IDLE on handshake of last word.
REQ-029 done SHALL pulse 1 the cycle after last-word handshake; busy=0 that cycle.
REQ-030 busy SHALL be 1 in READ and DRAIN, else 0.
REQ-031 Length 2**ADDR_WIDTH SHALL read every location once, ending at base_addr-1 (mod depth).

Reset
REQ-032 reset SHALL win over all other inputs in the same cycle, including start.
REQ-033 After reset: state IDLE, mem_addr=0, mem_we=0, out_valid=0, out_data=0, busy=0, done=0, FIFO and inflight cleared.
REQ-034 reset mid-burst SHALL abort: pending words discarded, no done pulse.

Verification
REQ-035 RAM preloaded data=addr^8'hA5, base=3, length=4, out_ready=1 -> out_data A6,A1,A0,A3 on 4 consecutive cycles from E0+2; done 1 cycle after last.
REQ-036 base=62, length=4, ADDR_WIDTH=6 -> addresses 62,63,0,1 read; data order matches.
REQ-037 length=8, out_ready toggled 1010... -> 8 words in order, none lost/repeated, out_data stable during stalls.
REQ-038 length=0 start -> done pulse one cycle later, out_valid stays 0, busy stays 0.
REQ-039 reset asserted at 3rd word of length=10 burst -> next cycle out_valid=0, busy=0, mem_addr=0; no done; new burst then works normally.
REQ-040 start pulsed again while busy -> ignored; first burst completes with its own length.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ============================================================================
//  Module   : ram_stream_reader
//  Purpose  : Reads a burst of consecutive words from a synchronous RAM and
//             streams them out over a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0]   c_rem_one  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_zero_len;
    logic                  w_last_pop;
    logic [2:0]            w_occupancy;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = (r_count != 2'd0) && out_ready;
        w_push       = r_inflight;
        // An address advance commits one word that lands in the FIFO on the
        // following edge; the current pop frees a slot in time for it.
        w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue      = (r_state == ST_READ) && (w_occupancy < 3'd2);
        w_accept     = (r_state == ST_IDLE) && start && (length != '0);
        w_zero_len   = (r_state == ST_IDLE) && start && (length == '0);
        w_last_pop   = (r_state == ST_DRAIN) && w_pop && (r_count == 2'd1) && !r_inflight;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (w_issue && (r_remaining == c_rem_one)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_pop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Address generator, RAM pipeline tracking and output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            // Holding the address keeps mem_q pointing at the same word.
            if (w_accept) begin
                r_mem_addr  <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_mem_addr  <= r_mem_addr + c_addr_one;
                r_remaining <= r_remaining - c_rem_one;
            end

            r_inflight <= w_issue;

            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_q;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            r_done <= w_zero_len || w_last_pop;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = 1'b0;
    assign out_data  = r_fifo[r_rd_ptr];
    assign out_valid = (r_count != 2'd0);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// ============================================================================
//  Module   : tb_ram_stream_reader
//  Purpose  : Self-checking bench for ram_stream_reader with a RAM model and
//             a queue-based reference of the expected word stream.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    int            errors = 0;
    int            checks = 0;
    int            ready_mode = 0;

    logic [DW-1:0] ram [DEPTH];

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM
    always @(posedge clk) mem_q <= ram[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer: inputs change 1 time unit after the falling edge
    always @(negedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Reference model: the expected stream is the list of RAM words of each
    // accepted burst; a word leaves it on every observed handshake.
    logic [DW-1:0] exp_q [$];
    bit            m_active = 1'b0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        logic exp_done;
        bit   m_before;
        if (reset) begin
            exp_q.delete();
            m_active = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_out_data", out_data, 0);
            prev_valid = 1'b0;
        end else begin
            exp_done = 1'b0;
            m_before = m_active;
            if (prev_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h but no word expected at %0t", prev_data, $time);
                end else begin
                    chk("stream_word", prev_data, exp_q.pop_front());
                    if (m_active && exp_q.size() == 0) begin
                        exp_done = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else if (prev_valid) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (start && !m_before) begin
                if (length == 0) begin
                    exp_done = 1'b1;
                end else begin
                    for (int i = 0; i < int'(length); i++)
                        exp_q.push_back(ram[(int'(base_addr) + i) % DEPTH]);
                    m_active = 1'b1;
                end
            end
            chk("done", done, exp_done);
            chk("busy", busy, m_active);
            chk("mem_we", mem_we, 0);
            if (!m_active) chk("idle_no_valid", out_valid, 0);
            prev_valid = out_valid;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Leaves the driver just after the falling edge that follows the start edge
    task automatic start_burst(input int b, input int l);
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || busy || out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (m_active || busy || out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: burst still active after %0d cycles (busy=%0b)", budget, busy);
        end
        tick();
    endtask

    task automatic expect_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(negedge clk);
        chk("lat_no_valid_e1", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_valid", out_valid, 1);
            chk("lit_data", out_data, w[i]);
        end
        @(negedge clk);
        chk("lit_done", done, 1);
        chk("lit_busy", busy, 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i) ^ 8'hA5;

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Basic burst: words A6,A1,A0,A3 from E0+2, done one cycle after last
        ready_mode = 0;
        start_burst(3, 4);
        chk("lit_mem_addr_base", mem_addr, 3);
        expect_words(8'hA6, 8'hA1, 8'hA0, 8'hA3);
        wait_idle(50);

        // Address wrap 62,63,0,1
        start_burst(62, 4);
        expect_words(8'h9B, 8'h9A, 8'hA5, 8'hA4);
        wait_idle(50);

        // Alternating back-pressure
        ready_mode = 1;
        start_burst(10, 8);
        wait_idle(100);

        // Zero-length burst
        ready_mode = 0;
        start_burst(5, 0);
        chk("zero_len_done", done, 1);
        chk("zero_len_valid", out_valid, 0);
        tick();
        chk("zero_len_done_end", done, 0);
        wait_idle(10);

        // Reset while the third word is on the output
        start_burst(30, 10);
        repeat (4) tick();
        chk("third_word_before_reset", out_data, ram[32]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        start_burst(50, 6);
        wait_idle(100);

        // Start while busy is ignored
        ready_mode = 2;
        start_burst(20, 5);
        tick();
        start_burst(40, 9);
        wait_idle(200);

        // Full-depth and randomized bursts
        for (int k = 0; k < 20; k++) begin
            ready_mode = $urandom_range(0, 3);
            if (k % 6 == 0) start_burst($urandom_range(0, DEPTH - 1), DEPTH);
            else            start_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 12));
            wait_idle(1000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
